// File: rtl/mem_sequencer_if.sv
// RAM-side bus of the record/playback sequencer: one write port and one read port
// of a single-clock block RAM (read data valid one cycle after the read enable).
interface mem_sequencer_if #(
    parameter int unsigned MEM_WIDTH = 16,
    parameter int unsigned MEM_DEPTH = 256,
    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
);
    logic                  mem_w_en;
    logic [ADDR_WIDTH-1:0] mem_w_addr;
    logic [MEM_WIDTH-1:0]  mem_w_data;
    logic                  mem_r_en;
    logic [ADDR_WIDTH-1:0] mem_r_addr;
    logic [MEM_WIDTH-1:0]  mem_r_data;

    // Sequencer side: drives both RAM ports, receives read data.
    modport master (
        output mem_w_en, mem_w_addr, mem_w_data,
        output mem_r_en, mem_r_addr,
        input  mem_r_data
    );

    // RAM side.
    modport slave (
        input  mem_w_en, mem_w_addr, mem_w_data,
        input  mem_r_en, mem_r_addr,
        output mem_r_data
    );
endinterface

// File: rtl/mem_sequencer.sv
// Record/playback controller: records in_data into consecutive RAM words, one per step,
// then plays the recorded sequence back in a loop with a 2-cycle read latency.
module mem_sequencer #(
    parameter int unsigned MEM_WIDTH   = 16,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned STEP_CYCLES = 12_000_000,
    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rec_start,
    input  logic                  play_start,
    input  logic                  stop,
    input  logic [MEM_WIDTH-1:0]  in_data,
    mem_sequencer_if.master       mem,
    output logic [MEM_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    output logic [1:0]            state,
    output logic [ADDR_WIDTH:0]   seq_len
);
    localparam int unsigned CNT_WIDTH = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(STEP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   PTR_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   PTR_LAST  = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   PTR_DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   seq_len_q, seq_len_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [MEM_WIDTH-1:0]  out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    logic active;
    logic step;
    logic wr_fire;
    logic rd_fire;

    always_comb begin
        active  = (state_q == S_RECORD) || (state_q == S_PLAY);
        step    = active && (cnt_q == '0) && !stop;
        wr_fire = step && (state_q == S_RECORD);
        rd_fire = step && (state_q == S_PLAY);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        seq_len_d   = seq_len_q;
        rd_pend_d   = 1'b0;
        // Read data arrives the cycle after the read enable; publish it one cycle later.
        out_valid_d = rd_pend_q;
        out_data_d  = rd_pend_q ? mem.mem_r_data : out_data_q;

        case (state_q)
            S_RECORD: begin
                if (stop) begin
                    state_d   = S_IDLE;
                    seq_len_d = wr_ptr_q;
                end else if (wr_fire) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (wr_ptr_q == PTR_LAST) begin
                        state_d   = S_IDLE;
                        seq_len_d = PTR_DEPTH;
                    end
                end
            end
            S_PLAY: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (rd_fire) begin
                    rd_pend_d = 1'b1;
                    rd_ptr_d  = (rd_ptr_q == seq_len_q - PTR_ONE) ? '0 : rd_ptr_q + PTR_ONE;
                end
            end
            default: begin
                // Also catches the unused encoding, which falls back to IDLE.
                state_d = S_IDLE;
                if (!stop) begin
                    if (rec_start) begin
                        state_d  = S_RECORD;
                        wr_ptr_d = '0;
                    end else if (play_start && (seq_len_q != '0)) begin
                        state_d  = S_PLAY;
                        rd_ptr_d = '0;
                    end
                end
            end
        endcase

        // Counter runs only while staying in an active state; entering one restarts it at 0.
        if (active && (state_d != S_IDLE)) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            seq_len_q   <= '0;
            rd_pend_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            seq_len_q   <= seq_len_d;
            rd_pend_q   <= rd_pend_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        mem.mem_w_en   = wr_fire;
        mem.mem_w_addr = wr_fire ? wr_ptr_q[ADDR_WIDTH-1:0] : '0;
        mem.mem_w_data = wr_fire ? in_data : '0;
        mem.mem_r_en   = rd_fire;
        mem.mem_r_addr = rd_fire ? rd_ptr_q[ADDR_WIDTH-1:0] : '0;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign state     = state_q;
    assign seq_len   = seq_len_q;
endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: behavioural RAM, event logs of the RAM bus and outputs, and a
// step-schedule model predicting which words are written, read and presented, and when.
module tb_mem_sequencer;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int SC = 4;
    localparam int AW = 3;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } ev_t;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          rec_start  = 1'b0;
    logic          play_start = 1'b0;
    logic          stop       = 1'b0;
    logic [W-1:0]  in_data    = '0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [1:0]    state;
    logic [AW:0]   seq_len;

    mem_sequencer_if #(.MEM_WIDTH(W), .MEM_DEPTH(D)) mem_if ();

    mem_sequencer #(
        .MEM_WIDTH   (W),
        .MEM_DEPTH   (D),
        .STEP_CYCLES (SC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rec_start  (rec_start),
        .play_start (play_start),
        .stop       (stop),
        .in_data    (in_data),
        .mem        (mem_if),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .state      (state),
        .seq_len    (seq_len)
    );

    always #5 clk = ~clk;

    // Behavioural block RAM, registered read.
    logic [W-1:0] ram [D];
    always @(posedge clk) begin
        if (mem_if.mem_w_en) ram[mem_if.mem_w_addr] <= mem_if.mem_w_data;
        if (mem_if.mem_r_en) mem_if.mem_r_data <= ram[mem_if.mem_r_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t wlog[$];
    ev_t rlog[$];
    ev_t olog[$];
    int  both_cnt = 0;
    int  bus_dirty_cnt = 0;

    always @(negedge clk) begin
        if (mem_if.mem_w_en && mem_if.mem_r_en) both_cnt++;
        if (!mem_if.mem_w_en && (mem_if.mem_w_addr != '0 || mem_if.mem_w_data != '0)) bus_dirty_cnt++;
        if (!mem_if.mem_r_en && mem_if.mem_r_addr != '0) bus_dirty_cnt++;
        if (mem_if.mem_w_en) wlog.push_back('{cyc, int'(mem_if.mem_w_addr), int'(mem_if.mem_w_data)});
        if (mem_if.mem_r_en) rlog.push_back('{cyc, int'(mem_if.mem_r_addr), 0});
        if (out_valid)       olog.push_back('{cyc, 0, int'(out_data)});
    end

    int tests = 0;
    int fails = 0;

    // Reference: recorded contents and length as the bench expects them.
    logic [W-1:0] mem_m [D];
    int  exp_len = 0;
    ev_t ew[$];
    ev_t er[$];
    ev_t eo[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_events(input string tag, input ev_t got[$], input ev_t want[$]);
        chk({tag, "_count"}, 32'(got.size()), 32'(want.size()));
        for (int i = 0; i < got.size() && i < want.size(); i++) begin
            chk({tag, "_cyc"},  32'(got[i].cyc),  32'(want[i].cyc));
            chk({tag, "_addr"}, 32'(got[i].addr), 32'(want[i].addr));
            chk({tag, "_data"}, 32'(got[i].data), 32'(want[i].data));
        end
    endtask

    // Record run: steps fall on cycles 1, 1+SC, ... after the pulse; stop_c=0 means no stop.
    task automatic record_run(input string tag, input int stop_c, input int n);
        int base;
        int k;
        int old;
        bit done;
        k = 0;
        done = 1'b0;
        old = exp_len;
        ew.delete();
        wlog.delete();
        rec_start = 1'b1;
        base = cyc;
        tick();
        rec_start = 1'b0;
        for (int c = 1; c <= n; c++) begin
            in_data = W'($urandom);
            stop = (c == stop_c);
            if (!done) begin
                if (c == stop_c) begin
                    done = 1'b1;
                    exp_len = k;
                end else if ((c - 1) % SC == 0) begin
                    ew.push_back('{base + c, k, int'(in_data)});
                    mem_m[k] = in_data;
                    k++;
                    if (k == D) begin
                        done = 1'b1;
                        exp_len = D;
                    end
                end
            end
            if (c == 2) chk({tag, "_len_held"}, 32'(seq_len), 32'(old));
            if (c == 2) chk({tag, "_state_rec"}, 32'(state), 32'(1));
            tick();
        end
        stop = 1'b0;
        cmp_events({tag, "_w"}, wlog, ew);
        chk({tag, "_state_end"}, 32'(state), 32'(0));
        chk({tag, "_seq_len"}, 32'(seq_len), 32'(exp_len));
    endtask

    // Play run: reads on step cycles before stop, word presented two cycles after each read.
    task automatic play_run(input string tag, input int stop_c, input int n, input int rec_c);
        int base;
        int k;
        int a;
        logic [W-1:0] last;
        k = 0;
        last = '0;
        er.delete();
        eo.delete();
        rlog.delete();
        olog.delete();
        play_start = 1'b1;
        base = cyc;
        tick();
        play_start = 1'b0;
        for (int c = 1; c <= n; c++) begin
            stop = (c == stop_c);
            rec_start = (rec_c != 0) && (c == rec_c);
            if (exp_len != 0 && c < stop_c && (c - 1) % SC == 0) begin
                a = k % exp_len;
                er.push_back('{base + c, a, 0});
                eo.push_back('{base + c + 2, 0, int'(mem_m[a])});
                last = mem_m[a];
                k++;
            end
            if (rec_c != 0 && c == rec_c + 1) chk({tag, "_rec_ignored"}, 32'(state), 32'(2));
            tick();
        end
        stop = 1'b0;
        rec_start = 1'b0;
        cmp_events({tag, "_r"}, rlog, er);
        cmp_events({tag, "_o"}, olog, eo);
        chk({tag, "_state_end"}, 32'(state), 32'(0));
        if (k > 0) chk({tag, "_out_hold"}, 32'(out_data), 32'(last));
    endtask

    initial begin
        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state",   32'(state),     32'(0));
        chk("rst_seq_len", 32'(seq_len),   32'(0));
        chk("rst_out",     32'(out_data),  32'(0));
        chk("rst_valid",   32'(out_valid), 32'(0));
        chk("rst_wen",     32'(mem_if.mem_w_en), 32'(0));
        chk("rst_ren",     32'(mem_if.mem_r_en), 32'(0));
        rst_n = 1'b1;
        tick();

        // play_start with nothing recorded is ignored.
        play_run("play_empty", 20, 23, 0);

        // Record three words, stop mid-step.
        record_run("rec3", 11, 14);

        // Looped playback, rec_start during PLAY ignored, stop with a read in flight.
        play_run("play3", 14, 17, 3);
        tick();
        chk("play3_out_after_idle", 32'(out_data), 32'(mem_m[0]));

        // stop and rec_start together in IDLE: stop wins.
        wlog.delete();
        stop = 1'b1;
        rec_start = 1'b1;
        tick();
        stop = 1'b0;
        rec_start = 1'b0;
        repeat (5) tick();
        chk("stop_rec_state",   32'(state),       32'(0));
        chk("stop_rec_len",     32'(seq_len),     32'(exp_len));
        chk("stop_rec_nowrite", 32'(wlog.size()), 32'(0));

        // Fill the RAM without stop: exactly D writes, then IDLE with seq_len=D.
        record_run("full", 0, 34);

        // Full-length loop wraps from the last address back to 0.
        play_run("play8", 35, 38, 0);

        // Asynchronous reset between a read and its output pulse.
        rlog.delete();
        olog.delete();
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        chk("mid_ren", 32'(mem_if.mem_r_en), 32'(1));
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_state", 32'(state),     32'(0));
        chk("async_len",   32'(seq_len),   32'(0));
        chk("async_valid", 32'(out_valid), 32'(0));
        chk("async_out",   32'(out_data),  32'(0));
        chk("async_wen",   32'(mem_if.mem_w_en), 32'(0));
        chk("async_ren",   32'(mem_if.mem_r_en), 32'(0));
        exp_len = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("async_no_pulse", 32'(olog.size()), 32'(0));
        play_run("play_after_rst", 10, 13, 0);

        chk("never_both_en", 32'(both_cnt),      32'(0));
        chk("idle_bus_zero", 32'(bus_dirty_cnt), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
